bus_burst_slave_ram: RTL and testbench

//  Bus responder (slave) for the shared burst bus: serves single and burst read/write transactions

---
 rtl/bus_burst_slave_ram_if.sv | 37 +++
 rtl/bus_burst_slave_ram.sv | 221 ++++++++++++++++++++++
 tb/tb_bus_burst_slave_ram.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_burst_slave_ram_if.sv
// ----------------------------------------------------------------------------
// bus_burst_slave_ram_if
// Purpose : shared burst bus bundle between a bus master and the burst slave RAM.
// Signals :
//   master -> slave : beginTransactionIn, endTransactionIn, readNotWriteIn,
//                     dataValidIn, busErrorIn, addressDataIn[31:0],
//                     byteEnablesIn[3:0], burstSizeIn[7:0]
//   slave -> master : endTransactionOut, dataValidOut, busErrorOut,
//                     addressDataOut[31:0]
// ----------------------------------------------------------------------------
interface bus_burst_slave_ram_if;
    logic        beginTransactionIn;
    logic        endTransactionIn;
    logic        readNotWriteIn;
    logic        dataValidIn;
    logic        busErrorIn;
    logic [31:0] addressDataIn;
    logic [3:0]  byteEnablesIn;
    logic [7:0]  burstSizeIn;

    logic        endTransactionOut;
    logic        dataValidOut;
    logic        busErrorOut;
    logic [31:0] addressDataOut;

    modport master (
        output beginTransactionIn, endTransactionIn, readNotWriteIn, dataValidIn,
               busErrorIn, addressDataIn, byteEnablesIn, burstSizeIn,
        input  endTransactionOut, dataValidOut, busErrorOut, addressDataOut
    );

    modport slave (
        input  beginTransactionIn, endTransactionIn, readNotWriteIn, dataValidIn,
               busErrorIn, addressDataIn, byteEnablesIn, burstSizeIn,
        output endTransactionOut, dataValidOut, busErrorOut, addressDataOut
    );
endinterface

// File: rtl/bus_burst_slave_ram.sv
// ----------------------------------------------------------------------------
// bus_burst_slave_ram
// Purpose : burst bus slave serving single/burst reads and writes from a local
//           dual-port SSRAM. Port A belongs to the bus FSM, port B is a plain
//           local read/write port.
// Ports   :
//   clock, reset        system clock, synchronous active-high reset
//   bus (slave modport) burst bus, see bus_burst_slave_ram_if
//   localAddress        port-B word address [ADDR_BITS-1:0]
//   localWe             port-B write enable
//   localDataIn         port-B write data
//   localDataOut        port-B read data, one cycle latency
// Build option : BUS_SLAVE_BYTE_ENABLES_EN
//   defined   -> bus writes update only the bytes selected by byteEnablesIn
//   undefined -> byteEnablesIn ignored, bus writes update the full word
// ----------------------------------------------------------------------------
module bus_burst_slave_ram #(
    parameter logic [31:0]  BASE_ADDRESS = 32'h5000_0000,
    parameter int unsigned  NR_OF_WORDS  = 512,
    localparam int unsigned ADDR_BITS    = $clog2(NR_OF_WORDS)
) (
    input  logic                 clock,
    input  logic                 reset,
    bus_burst_slave_ram_if.slave bus,
    input  logic [ADDR_BITS-1:0] localAddress,
    input  logic                 localWe,
    input  logic [31:0]          localDataIn,
    output logic [31:0]          localDataOut
);

    localparam int unsigned TAG_LSB = ADDR_BITS + 2;
    localparam int unsigned CNT_W   = 9;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RSETUP,
        S_RBURST,
        S_REND,
        S_WRITE,
        S_ERROR
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [ADDR_BITS-1:0] r_index, w_index_nxt;
    logic [CNT_W-1:0]     r_count, w_count_nxt;
    logic                 r_dv, w_dv_nxt;
    logic                 r_end, w_end_nxt;
    logic                 r_err, w_err_nxt;
    logic                 w_hit;
    logic                 w_in_range;
    logic                 w_a_re;
    logic                 w_a_we;
    logic [31:0]          r_a_dout;
    logic [31:0]          r_b_dout;
    logic [31:0]          r_mem [NR_OF_WORDS];

`ifdef BUS_SLAVE_BYTE_ENABLES_EN
    logic [3:0]           r_be;
    logic                 w_unused;
    assign w_unused = ^bus.addressDataIn[1:0];
`else
    logic                 w_unused;
    assign w_unused = ^{bus.addressDataIn[1:0], bus.byteEnablesIn};
`endif

    // Window decode and range check on the begin cycle (no wrap-around allowed)
    assign w_hit      = bus.beginTransactionIn &&
                        (bus.addressDataIn[31:TAG_LSB] == BASE_ADDRESS[31:TAG_LSB]);
    assign w_in_range = (32'(bus.addressDataIn[TAG_LSB-1:2]) + 32'(bus.burstSizeIn))
                        < 32'(NR_OF_WORDS);

    // Next-state and next-output logic; outputs are registered one edge later
    always_comb begin
        w_state_nxt = r_state;
        w_index_nxt = r_index;
        w_count_nxt = r_count;
        w_dv_nxt    = 1'b0;
        w_end_nxt   = 1'b0;
        w_err_nxt   = 1'b0;
        w_a_re      = 1'b0;
        w_a_we      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_hit) begin
                    w_index_nxt = bus.addressDataIn[TAG_LSB-1:2];
                    if (!w_in_range) begin
                        w_state_nxt = S_ERROR;
                        w_err_nxt   = 1'b1;
                        w_end_nxt   = 1'b1;
                    end else if (bus.readNotWriteIn) begin
                        w_state_nxt = S_RSETUP;
                        w_count_nxt = CNT_W'(bus.burstSizeIn);
                    end else begin
                        w_state_nxt = S_WRITE;
                        w_count_nxt = CNT_W'(bus.burstSizeIn) + CNT_W'(1);
                    end
                end
            end
            // First read issued here; its data and dataValid land together next cycle
            S_RSETUP: begin
                w_a_re      = 1'b1;
                w_dv_nxt    = 1'b1;
                w_index_nxt = r_index + ADDR_BITS'(1);
                w_state_nxt = S_RBURST;
            end
            // r_count holds the reads still to issue after the first one
            S_RBURST: begin
                if (r_count != '0) begin
                    w_a_re      = 1'b1;
                    w_dv_nxt    = 1'b1;
                    w_index_nxt = r_index + ADDR_BITS'(1);
                    w_count_nxt = r_count - CNT_W'(1);
                end else begin
                    w_end_nxt   = 1'b1;
                    w_state_nxt = S_REND;
                end
            end
            S_REND: begin
                w_state_nxt = S_IDLE;
            end
            // r_count holds the beats still accepted; extra beats are dropped
            S_WRITE: begin
                if (bus.dataValidIn && (r_count != '0)) begin
                    w_a_we      = 1'b1;
                    w_index_nxt = r_index + ADDR_BITS'(1);
                    w_count_nxt = r_count - CNT_W'(1);
                end
                if (bus.endTransactionIn) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ERROR: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Master abort wins over everything in an active transaction
        if ((r_state != S_IDLE) && bus.busErrorIn) begin
            w_state_nxt = S_IDLE;
            w_dv_nxt    = 1'b0;
            w_end_nxt   = 1'b0;
            w_err_nxt   = 1'b0;
            w_a_re      = 1'b0;
            w_a_we      = 1'b0;
        end

        // A beat coinciding with reset is not committed
        if (reset) begin
            w_a_we = 1'b0;
        end
    end

    // FSM state and registered bus outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_index <= '0;
            r_count <= '0;
            r_dv    <= 1'b0;
            r_end   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_index <= w_index_nxt;
            r_count <= w_count_nxt;
            r_dv    <= w_dv_nxt;
            r_end   <= w_end_nxt;
            r_err   <= w_err_nxt;
        end
    end

`ifdef BUS_SLAVE_BYTE_ENABLES_EN
    // Byte enables captured with the accepted begin
    always_ff @(posedge clock) begin
        if (reset) begin
            r_be <= '0;
        end else if ((r_state == S_IDLE) && w_hit) begin
            r_be <= bus.byteEnablesIn;
        end
    end
`endif

    // Port A read register; zero when no beat so the OR-combined bus stays clean
    always_ff @(posedge clock) begin
        if (reset) begin
            r_a_dout <= '0;
        end else begin
            r_a_dout <= w_a_re ? r_mem[r_index] : '0;
        end
    end

    // SSRAM array: port A write first so a same-address port B write wins
    always_ff @(posedge clock) begin
        if (w_a_we) begin
`ifdef BUS_SLAVE_BYTE_ENABLES_EN
            for (int b = 0; b < 4; b++) begin
                if (r_be[b]) begin
                    r_mem[r_index][8*b +: 8] <= bus.addressDataIn[8*b +: 8];
                end
            end
`else
            r_mem[r_index] <= bus.addressDataIn;
`endif
        end
        if (localWe) begin
            r_mem[localAddress] <= localDataIn;
        end
        r_b_dout <= r_mem[localAddress];
    end

    assign bus.dataValidOut      = r_dv;
    assign bus.endTransactionOut = r_end;
    assign bus.busErrorOut       = r_err;
    assign bus.addressDataOut    = r_a_dout;
    assign localDataOut          = r_b_dout;

endmodule

// File: tb/tb_bus_burst_slave_ram.sv
// ----------------------------------------------------------------------------
// tb_bus_burst_slave_ram
// Purpose : directed self-checking bench for bus_burst_slave_ram.
//           Inputs change 1 time unit after the rising edge, outputs are
//           observed at the same point, i.e. just after the edge that made them.
// ----------------------------------------------------------------------------
module tb_bus_burst_slave_ram;

    logic        clock = 1'b0;
    logic        reset;
    logic [8:0]  localAddress;
    logic        localWe;
    logic [31:0] localDataIn;
    logic [31:0] localDataOut;
    logic [31:0] rd;

    int n_checks = 0;
    int n_errors = 0;

    bus_burst_slave_ram_if bus_if ();

    bus_burst_slave_ram #(
        .BASE_ADDRESS (32'h5000_0000),
        .NR_OF_WORDS  (512)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .bus          (bus_if),
        .localAddress (localAddress),
        .localWe      (localWe),
        .localDataIn  (localDataIn),
        .localDataOut (localDataOut)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic dv, input logic et,
                            input logic er, input logic [31:0] data);
        chk({tag, "_dv"},   32'(bus_if.dataValidOut),      32'(dv));
        chk({tag, "_end"},  32'(bus_if.endTransactionOut), 32'(et));
        chk({tag, "_err"},  32'(bus_if.busErrorOut),       32'(er));
        chk({tag, "_data"}, bus_if.addressDataOut,         data);
    endtask

    task automatic bus_idle();
        bus_if.beginTransactionIn = 1'b0;
        bus_if.endTransactionIn   = 1'b0;
        bus_if.readNotWriteIn     = 1'b0;
        bus_if.dataValidIn        = 1'b0;
        bus_if.busErrorIn         = 1'b0;
        bus_if.addressDataIn      = 32'h0;
        bus_if.byteEnablesIn      = 4'h0;
        bus_if.burstSizeIn        = 8'h0;
    endtask

    // Begin cycle; returns one cycle after the begin was sampled (+1)
    task automatic start(input logic [31:0] addr, input logic rnw,
                         input logic [7:0] burst, input logic [3:0] be);
        bus_if.beginTransactionIn = 1'b1;
        bus_if.addressDataIn      = addr;
        bus_if.readNotWriteIn     = rnw;
        bus_if.burstSizeIn        = burst;
        bus_if.byteEnablesIn      = be;
        tick();
        bus_idle();
    endtask

    task automatic ram_wr(input logic [8:0] idx, input logic [31:0] data);
        localAddress = idx;
        localDataIn  = data;
        localWe      = 1'b1;
        tick();
        localWe      = 1'b0;
    endtask

    task automatic ram_rd(input logic [8:0] idx, output logic [31:0] data);
        localAddress = idx;
        localWe      = 1'b0;
        tick();
        data = localDataOut;
    endtask

    initial begin
        bus_idle();
        localAddress = '0;
        localWe      = 1'b0;
        localDataIn  = '0;
        reset        = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk_outs("reset", 1'b0, 1'b0, 1'b0, 32'h0);

        // Preload through port B
        ram_wr(9'd0,   32'h0000_0011);
        ram_wr(9'd1,   32'h0000_0022);
        ram_wr(9'd2,   32'h0000_0033);
        ram_wr(9'd3,   32'h0000_0044);
        ram_wr(9'd6,   32'h6666_6666);
        ram_wr(9'd7,   32'h7777_7777);
        ram_wr(9'd8,   32'hFFFF_FFFF);
        ram_wr(9'd9,   32'h9999_9999);
        ram_wr(9'd10,  32'h1010_1010);
        ram_wr(9'd12,  32'h1212_1212);
        ram_wr(9'd13,  32'h1313_1313);
        ram_wr(9'd510, 32'h5105_1051);
        ram_wr(9'd511, 32'h5115_1151);

        // 1: read burst of 4 from index 0
        start(32'h5000_0000, 1'b1, 8'd3, 4'hF);
        chk_outs("t1_c1", 1'b0, 1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk_outs($sformatf("t1_beat%0d", k), 1'b1, 1'b0, 1'b0, 32'h11 * (k + 1));
        end
        tick();
        chk_outs("t1_end", 1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        chk_outs("t1_idle", 1'b0, 1'b0, 1'b0, 32'h0);

        // 2: write burst of 2 at index 4; third beat is beyond the burst and dropped
        start(32'h5000_0010, 1'b0, 8'd1, 4'hF);
        bus_if.dataValidIn   = 1'b1;
        bus_if.addressDataIn = 32'hCAFE_BABE;
        tick();
        bus_if.addressDataIn = 32'hDEAD_BEEF;
        tick();
        bus_if.addressDataIn    = 32'h0BAD_F00D;
        bus_if.endTransactionIn = 1'b1;
        tick();
        bus_idle();
        chk_outs("t2_outs", 1'b0, 1'b0, 1'b0, 32'h0);
        ram_rd(9'd4, rd); chk("t2_idx4", rd, 32'hCAFE_BABE);
        ram_rd(9'd5, rd); chk("t2_idx5", rd, 32'hDEAD_BEEF);
        ram_rd(9'd6, rd); chk("t2_idx6", rd, 32'h6666_6666);

        // 3a: last legal burst ending exactly at index 511
        start(32'h5000_07F8, 1'b1, 8'd1, 4'hF);
        chk_outs("t3a_c1", 1'b0, 1'b0, 1'b0, 32'h0);
        tick(); chk_outs("t3a_b0", 1'b1, 1'b0, 1'b0, 32'h5105_1051);
        tick(); chk_outs("t3a_b1", 1'b1, 1'b0, 1'b0, 32'h5115_1151);
        tick(); chk_outs("t3a_end", 1'b0, 1'b1, 1'b0, 32'h0);
        tick();

        // 3b: out-of-range read from index 511
        start(32'h5000_07FC, 1'b1, 8'd1, 4'hF);
        chk_outs("t3b_err", 1'b0, 1'b1, 1'b1, 32'h0);
        tick(); chk_outs("t3b_c2", 1'b0, 1'b0, 1'b0, 32'h0);
        tick(); chk_outs("t3b_c3", 1'b0, 1'b0, 1'b0, 32'h0);

        // 3c: out-of-range write must not touch the SSRAM
        start(32'h5000_07FC, 1'b0, 8'd1, 4'hF);
        chk_outs("t3c_err", 1'b0, 1'b1, 1'b1, 32'h0);
        bus_if.dataValidIn   = 1'b1;
        bus_if.addressDataIn = 32'hBAD0_BAD0;
        tick();
        bus_idle();
        chk_outs("t3c_c2", 1'b0, 1'b0, 1'b0, 32'h0);
        ram_rd(9'd511, rd); chk("t3c_idx511", rd, 32'h5115_1151);

        // 4: misses are ignored, then a hit is served
        start(32'h6000_0000, 1'b1, 8'd0, 4'hF);
        chk_outs("t4_miss_c1", 1'b0, 1'b0, 1'b0, 32'h0);
        tick(); chk_outs("t4_miss_c2", 1'b0, 1'b0, 1'b0, 32'h0);
        tick(); chk_outs("t4_miss_c3", 1'b0, 1'b0, 1'b0, 32'h0);
        start(32'h5000_0800, 1'b1, 8'd0, 4'hF);
        chk_outs("t4_nextwin_c1", 1'b0, 1'b0, 1'b0, 32'h0);
        tick(); chk_outs("t4_nextwin_c2", 1'b0, 1'b0, 1'b0, 32'h0);
        start(32'h5000_0004, 1'b1, 8'd0, 4'hF);
        chk_outs("t4_hit_c1", 1'b0, 1'b0, 1'b0, 32'h0);
        tick(); chk_outs("t4_hit_b0", 1'b1, 1'b0, 1'b0, 32'h0000_0022);
        tick(); chk_outs("t4_hit_end", 1'b0, 1'b1, 1'b0, 32'h0);
        tick();

        // 5a: busErrorIn during the third beat of an 8-beat read
        start(32'h5000_0000, 1'b1, 8'd7, 4'hF);
        tick(); chk_outs("t5a_b0", 1'b1, 1'b0, 1'b0, 32'h0000_0011);
        tick(); chk_outs("t5a_b1", 1'b1, 1'b0, 1'b0, 32'h0000_0022);
        tick(); chk_outs("t5a_b2", 1'b1, 1'b0, 1'b0, 32'h0000_0033);
        bus_if.busErrorIn = 1'b1;
        tick(); chk_outs("t5a_abort", 1'b0, 1'b0, 1'b0, 32'h0);
        bus_if.busErrorIn = 1'b0;
        tick(); chk_outs("t5a_after1", 1'b0, 1'b0, 1'b0, 32'h0);
        tick(); chk_outs("t5a_after2", 1'b0, 1'b0, 1'b0, 32'h0);
        start(32'h5000_001C, 1'b1, 8'd0, 4'hF);
        tick(); chk_outs("t5a_recover", 1'b1, 1'b0, 1'b0, 32'h7777_7777);
        tick(); chk_outs("t5a_rec_end", 1'b0, 1'b1, 1'b0, 32'h0);
        tick();

        // 5b: reset during the third beat of an 8-beat read
        start(32'h5000_0000, 1'b1, 8'd7, 4'hF);
        tick(); chk_outs("t5b_b0", 1'b1, 1'b0, 1'b0, 32'h0000_0011);
        tick(); chk_outs("t5b_b1", 1'b1, 1'b0, 1'b0, 32'h0000_0022);
        tick(); chk_outs("t5b_b2", 1'b1, 1'b0, 1'b0, 32'h0000_0033);
        reset = 1'b1;
        tick(); chk_outs("t5b_reset", 1'b0, 1'b0, 1'b0, 32'h0);
        reset = 1'b0;
        tick(); chk_outs("t5b_after1", 1'b0, 1'b0, 1'b0, 32'h0);
        tick(); chk_outs("t5b_after2", 1'b0, 1'b0, 1'b0, 32'h0);

        // 5c: reset mid write burst keeps the beat already written
        start(32'h5000_0030, 1'b0, 8'd3, 4'hF);
        bus_if.dataValidIn   = 1'b1;
        bus_if.addressDataIn = 32'hAAAA_5555;
        tick();
        bus_idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_outs("t5c_reset", 1'b0, 1'b0, 1'b0, 32'h0);
        ram_rd(9'd12, rd); chk("t5c_idx12", rd, 32'hAAAA_5555);
        ram_rd(9'd13, rd); chk("t5c_idx13", rd, 32'h1313_1313);

        // 6: byte enables
        start(32'h5000_0020, 1'b0, 8'd0, 4'b0101);
        bus_if.dataValidIn      = 1'b1;
        bus_if.addressDataIn    = 32'h1234_5678;
        bus_if.endTransactionIn = 1'b1;
        tick();
        bus_idle();
        ram_rd(9'd8, rd);
`ifdef BUS_SLAVE_BYTE_ENABLES_EN
        chk("t6_be0101", rd, 32'hFF34_FF78);
`else
        chk("t6_be0101", rd, 32'h1234_5678);
`endif
        start(32'h5000_0028, 1'b0, 8'd0, 4'b0000);
        bus_if.dataValidIn      = 1'b1;
        bus_if.addressDataIn    = 32'hDEAD_0000;
        bus_if.endTransactionIn = 1'b1;
        tick();
        bus_idle();
        ram_rd(9'd10, rd);
`ifdef BUS_SLAVE_BYTE_ENABLES_EN
        chk("t6_be0000", rd, 32'h1010_1010);
`else
        chk("t6_be0000", rd, 32'hDEAD_0000);
`endif

        // 7: same-address collision: port B write wins, port B read sees old data
        start(32'h5000_0024, 1'b0, 8'd0, 4'hF);
        bus_if.dataValidIn      = 1'b1;
        bus_if.addressDataIn    = 32'hA0A0_A0A0;
        bus_if.endTransactionIn = 1'b1;
        localAddress = 9'd9;
        localDataIn  = 32'hB0B0_B0B0;
        localWe      = 1'b1;
        tick();
        localWe = 1'b0;
        bus_idle();
        chk("t7_old_read", localDataOut, 32'h9999_9999);
        ram_rd(9'd9, rd); chk("t7_portb_wins", rd, 32'hB0B0_B0B0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
